// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits (LSB/MSB first), even parity, 1/1.5/2 stop bits.
// Optional line-break forcing is built when UART_TX_BREAK_EN is defined.
module uart_tx (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [31:0] i_bit_length,
  input  logic        i_msb_first,
  input  logic [1:0]  i_stop_bit_mode,
  input  logic        i_hw_flow_control_enable,
  input  logic        i_cts_n,
  input  logic        i_tx_valid,
  input  logic [7:0]  i_tx_word,
  output logic        o_tx_ready,
  output logic        o_tx,
  output logic        o_tx_started,
  output logic        o_tx_done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic        i_break
`endif
);

  typedef enum logic [2:0] {
    StIdle, StWaitCts, StStart, StData, StParity, StStop, StStop2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  word_q, word_d;
  logic        parity_q, parity_d;
  logic        msb_q, msb_d;
  logic [1:0]  stop_q, stop_d;
  logic        tx_q, tx_d;
  logic        started_q, started_d;

  logic        accept;
  logic        bit_end;
  logic [31:0] len_in;
  logic [31:0] half_len;
  logic [2:0]  first_idx;
  logic [2:0]  last_idx;
  logic [2:0]  next_idx;
  logic        final_stop;

  assign len_in     = (i_bit_length == 32'd0) ? 32'd1 : i_bit_length;
  assign half_len   = (len_q[31:1] == 31'd0) ? 32'd1 : {1'b0, len_q[31:1]};
  assign bit_end    = (cnt_q == 32'd0);
  assign first_idx  = msb_q ? 3'd7 : 3'd0;
  assign last_idx   = msb_q ? 3'd0 : 3'd7;
  assign next_idx   = msb_q ? (bit_idx_q - 3'd1) : (bit_idx_q + 3'd1);
  assign final_stop = (state_q == StStop2) || ((state_q == StStop) && (stop_q == 2'b00));

`ifdef UART_TX_BREAK_EN
  assign o_tx_ready = (state_q == StIdle) && !i_break;
  assign o_tx_done  = final_stop && bit_end && !i_break;
`else
  assign o_tx_ready = (state_q == StIdle);
  assign o_tx_done  = final_stop && bit_end;
`endif

  assign accept       = i_tx_valid && o_tx_ready;
  assign o_tx         = tx_q;
  assign o_tx_started = started_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    bit_idx_d = bit_idx_q;
    word_d    = word_q;
    parity_d  = parity_q;
    msb_d     = msb_q;
    stop_d    = stop_q;
    tx_d      = tx_q;
    started_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (accept) begin
          word_d   = i_tx_word;
          parity_d = ^i_tx_word;
          len_d    = len_in;
          msb_d    = i_msb_first;
          stop_d   = i_stop_bit_mode;
          if (!i_hw_flow_control_enable || !i_cts_n) begin
            state_d   = StStart;
            tx_d      = 1'b0;
            cnt_d     = len_in - 32'd1;
            started_d = 1'b1;
          end else begin
            state_d = StWaitCts;
          end
        end
      end
      StWaitCts: begin
        tx_d = 1'b1;
        if (!i_cts_n) begin
          state_d   = StStart;
          tx_d      = 1'b0;
          cnt_d     = len_q - 32'd1;
          started_d = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = first_idx;
          tx_d      = word_q[first_idx];
          cnt_d     = len_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = len_q - 32'd1;
          if (bit_idx_q == last_idx) begin
            state_d = StParity;
            tx_d    = parity_q;
          end else begin
            bit_idx_d = next_idx;
            tx_d      = word_q[next_idx];
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
          cnt_d   = len_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_q == 2'b00) begin
            state_d = StIdle;
          end else begin
            state_d = StStop2;
            // Mode 10 gives a half-length second stop bit (1.5 stop bits total).
            cnt_d   = (stop_q == 2'b10) ? (half_len - 32'd1) : (len_q - 32'd1);
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StStop2: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

`ifdef UART_TX_BREAK_EN
    if (i_break) begin
      state_d   = StIdle;
      tx_d      = 1'b0;
      cnt_d     = 32'd0;
      started_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q   <= StIdle;
      cnt_q     <= 32'd0;
      len_q     <= 32'd0;
      bit_idx_q <= 3'd0;
      word_q    <= 8'd0;
      parity_q  <= 1'b0;
      msb_q     <= 1'b0;
      stop_q    <= 2'b00;
      tx_q      <= 1'b1;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      bit_idx_q <= bit_idx_d;
      word_q    <= word_d;
      parity_q  <= parity_d;
      msb_q     <= msb_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      started_q <= started_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor checks the line
// cycle by cycle against a frame model built from the framing rules.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] bit_len;
  logic        msb;
  logic [1:0]  stop_mode;
  logic        fc;
  logic        cts_n;
  logic        valid;
  logic [7:0]  word;
  logic        ready;
  logic        tx;
  logic        started;
  logic        done;
`ifdef UART_TX_BREAK_EN
  logic        brk;
`endif

  always #5 clk = ~clk;

  uart_tx dut (
    .i_clk                    (clk),
    .i_nrst                   (nrst),
    .i_bit_length             (bit_len),
    .i_msb_first              (msb),
    .i_stop_bit_mode          (stop_mode),
    .i_hw_flow_control_enable (fc),
    .i_cts_n                  (cts_n),
    .i_tx_valid               (valid),
    .i_tx_word                (word),
    .o_tx_ready               (ready),
    .o_tx                     (tx),
    .o_tx_started             (started),
    .o_tx_done                (done)
`ifdef UART_TX_BREAK_EN
    ,
    .i_break                  (brk)
`endif
  );

  typedef struct packed {
    logic [7:0] w;
    int         len;
    logic       msb;
    logic [1:0] mode;
    int         start;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     abort_edges = 0;
  bit     mon_busy = 1'b0;

  // Edges at which the frame in flight gets aborted (reset or line break).
  always @(posedge clk) begin
    cyc <= cyc + 1;
`ifdef UART_TX_BREAK_EN
    if (!nrst || brk) abort_edges <= abort_edges + 1;
`else
    if (!nrst) abort_edges <= abort_edges + 1;
`endif
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int frame_len(input frame_t f);
    case (f.mode)
      2'b00:   return 11 * f.len;
      2'b10:   return 11 * f.len + (((f.len / 2) < 1) ? 1 : (f.len / 2));
      default: return 12 * f.len;
    endcase
  endfunction

  // Line level at sample s of the frame: start, data, parity, then stop bits.
  function automatic logic exp_bit(input frame_t f, input int s);
    int b;
    b = s / f.len;
    if (b == 0) return 1'b0;
    if (b <= 8) return f.msb ? f.w[8 - b] : f.w[b - 1];
    if (b == 9) return ^f.w;
    return 1'b1;
  endfunction

  // Monitor
  initial begin
    frame_t f;
    int     n;
    int     seen;
    bit     aborted;
    seen = 0;
    forever begin
      @(negedge clk);
      seen = abort_edges;
      if (!started) begin
        chk("idle_done", 32'(done), 0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_start", 32'(started), 0);
      end else begin
        f = exp_q.pop_front();
        mon_busy = 1'b1;
        chk("start_cycle", cyc, f.start);
        n = frame_len(f);
        aborted = 1'b0;
        for (int s = 0; s < n; s++) begin
          if (s > 0) @(negedge clk);
          if (abort_edges != seen) begin
            aborted = 1'b1;
            break;
          end
          chk("tx_bit", 32'(tx), 32'(exp_bit(f, s)));
          chk("done_pulse", 32'(done), 32'(s == n - 1));
          chk("busy_ready", 32'(ready), 0);
        end
        if (!aborted) begin
          @(negedge clk);
          chk("after_ready", 32'(ready), 1);
          chk("after_tx", 32'(tx), 1);
          chk("after_done", 32'(done), 0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] w, input int l, input logic m, input logic [1:0] md,
                      input int extra, input bit hold);
    int     t;
    frame_t f;
    t = 0;
    @(negedge clk);
    while (!ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("ready_timeout", 32'(ready), 1);
    word      = w;
    bit_len   = l;
    msb       = m;
    stop_mode = md;
    valid     = 1'b1;
    f.w       = w;
    f.len     = (l == 0) ? 1 : l;
    f.msb     = m;
    f.mode    = md;
    f.start   = cyc + 1 + extra;
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    if (!hold) begin
      valid     = 1'b0;
      word      = 8'($urandom);
      bit_len   = $urandom_range(1, 9);
      msb       = 1'($urandom);
      stop_mode = 2'($urandom);
    end
  endtask

  initial begin
    int t;
    nrst      = 1'b0;
    valid     = 1'b0;
    word      = 8'h00;
    bit_len   = 32'd4;
    msb       = 1'b0;
    stop_mode = 2'b00;
    fc        = 1'b0;
    cts_n     = 1'b1;
`ifdef UART_TX_BREAK_EN
    brk       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", 32'(tx), 1);
    chk("reset_ready", 32'(ready), 1);
    chk("reset_started", 32'(started), 0);
    chk("reset_done", 32'(done), 0);
    nrst = 1'b1;

    send(8'hA5, 4, 1'b0, 2'b00, 0, 1'b0);
    send(8'h07, 2, 1'b1, 2'b01, 0, 1'b0);
    send(8'h00, 6, 1'b0, 2'b10, 0, 1'b0);
    send(8'h5A, 1, 1'b0, 2'b10, 0, 1'b0);

    // Flow control: held off by CTS, then mid-frame CTS toggles must not matter.
    fc    = 1'b1;
    cts_n = 1'b1;
    send(8'h3C, 3, 1'b0, 2'b00, 20, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("cts_wait_tx", 32'(tx), 1);
      chk("cts_wait_ready", 32'(ready), 0);
    end
    cts_n = 1'b0;
    repeat (8) @(negedge clk);
    cts_n = 1'b1;
    repeat (5) @(negedge clk);
    cts_n = 1'b0;
    repeat (3) @(negedge clk);
    cts_n = 1'b1;
    fc    = 1'b0;

    // Back-to-back with valid held and the word changing mid-frame.
    send(8'h11, 3, 1'b0, 2'b00, 0, 1'b1);
    word = 8'h22;
    send(8'h22, 3, 1'b0, 2'b00, 0, 1'b1);
    word = 8'h99;
    repeat (5) @(negedge clk);
    valid = 1'b0;

    // Reset during data bit 3 (samples 16..19 of an L=4 frame).
    send(8'hC3, 4, 1'b0, 2'b00, 0, 1'b0);
    repeat (18) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_ready", 32'(ready), 1);
    chk("midrst_started", 32'(started), 0);
    nrst = 1'b1;
    send(8'h96, 2, 1'b1, 2'b11, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      send(8'($urandom), $urandom_range(0, 6), 1'($urandom), 2'($urandom), 0, 1'b0);
    end

`ifdef UART_TX_BREAK_EN
    send(8'hF0, 4, 1'b0, 2'b01, 0, 1'b0);
    repeat (10) @(negedge clk);
    brk = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("break_tx", 32'(tx), 0);
      chk("break_done", 32'(done), 0);
      chk("break_ready", 32'(ready), 0);
    end
    brk = 1'b0;
    @(negedge clk);
    chk("break_release_tx", 32'(tx), 1);
    send(8'h3A, 3, 1'b1, 2'b00, 0, 1'b0);
`endif

    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
